// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, H/V counters, syncs, blanking, latched IRQ.
// All outputs registered from next-counter values, so decodes never lag the counters; no backpressure.
module video_timing_gen #(
  parameter int PIX_DIV      = 4,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 304,
  parameter int H_SYNC_WIDTH = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_WIDTH = 8,
  parameter int IRQ_LINE     = 224,
  parameter int HW           = $clog2(H_TOTAL),
  parameter int VW           = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          irq_en,
  input  logic          irq_ack,
  output logic          pix_ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          csync_n,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq_n
);

  if (!(PIX_DIV >= 1 && H_ACTIVE <= H_TOTAL && V_ACTIVE <= V_TOTAL && IRQ_LINE < V_TOTAL &&
        H_SYNC_WIDTH >= 1 && H_SYNC_WIDTH < H_TOTAL && V_SYNC_WIDTH >= 1 &&
        V_SYNC_WIDTH < V_TOTAL && H_SYNC_START < H_TOTAL && V_SYNC_START < V_TOTAL))
  begin : g_bad_params
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] IRQ_V    = VW'(IRQ_LINE);

  // Sync windows may run past the total; the wrapped part is split into [LO,total) + [0,HI).
  localparam int H_SYNC_END  = H_SYNC_START + H_SYNC_WIDTH;
  localparam int V_SYNC_END  = V_SYNC_START + V_SYNC_WIDTH;
  localparam bit H_SYNC_WRAP = (H_SYNC_END > H_TOTAL);
  localparam bit V_SYNC_WRAP = (V_SYNC_END > V_TOTAL);
  localparam logic [HW:0] HS_LO = (HW+1)'(H_SYNC_START);
  localparam logic [HW:0] HS_HI = (HW+1)'(H_SYNC_WRAP ? H_SYNC_END - H_TOTAL : H_SYNC_END);
  localparam logic [VW:0] VS_LO = (VW+1)'(V_SYNC_START);
  localparam logic [VW:0] VS_HI = (VW+1)'(V_SYNC_WRAP ? V_SYNC_END - V_TOTAL : V_SYNC_END);
  localparam logic [HW:0] HA    = (HW+1)'(H_ACTIVE);
  localparam logic [VW:0] VA    = (VW+1)'(V_ACTIVE);

  logic [DW-1:0] div_q, div_d;
  logic          pix_ce_q, pix_ce_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          irq_n_q, irq_n_d;
  logic          hsync_n_q, vsync_n_q, csync_n_q;
  logic          hblank_q, vblank_q, de_q, line_start_q, frame_start_q;
  logic [HW:0]   hx;
  logic [VW:0]   vx;
  logic          hs_act, vs_act, hb_d, vb_d, irq_set;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end
    if (rst) begin
      div_d    = '0;
      hcount_d = '0;
      vcount_d = '0;
    end
    // Reset value also covers PIX_DIV==1, where the enable is permanently high.
    pix_ce_d = rst ? (PIX_DIV == 1) : (div_d == DIV_LAST);

    hx     = {1'b0, hcount_d};
    vx     = {1'b0, vcount_d};
    hs_act = H_SYNC_WRAP ? ((hx >= HS_LO) || (hx < HS_HI)) : ((hx >= HS_LO) && (hx < HS_HI));
    vs_act = V_SYNC_WRAP ? ((vx >= VS_LO) || (vx < VS_HI)) : ((vx >= VS_LO) && (vx < VS_HI));
    hb_d   = (hx >= HA);
    vb_d   = (vx >= VA);

    irq_set = !rst && pix_ce_q && irq_en && (hcount_d == '0) && (vcount_d == IRQ_V);
    irq_n_d = irq_n_q;
    if (irq_ack) irq_n_d = 1'b1;
    if (irq_set) irq_n_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      pix_ce_q <= pix_ce_d;
      hcount_q <= '0;
      vcount_q <= '0;
      irq_n_q  <= 1'b1;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      irq_n_q  <= irq_n_d;
    end
  end

  // Decodes follow the next-counter values, which are already forced to (0,0) during reset.
  always_ff @(posedge clk) begin
    hsync_n_q     <= !hs_act;
    vsync_n_q     <= !vs_act;
    csync_n_q     <= !hs_act && !vs_act;
    hblank_q      <= hb_d;
    vblank_q      <= vb_d;
    de_q          <= !hb_d && !vb_d;
    line_start_q  <= (hcount_d == '0);
    frame_start_q <= (hcount_d == '0) && (vcount_d == '0);
  end

  assign pix_ce      = pix_ce_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign csync_n     = csync_n_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign irq_n       = irq_n_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 10x6 raster with a 2-clk pixel.
module tb_video_timing_gen;

  logic       clk;
  logic       rst;
  logic       irq_en;
  logic       irq_ack;
  logic       pix_ce;
  logic [3:0] hcount;
  logic [2:0] vcount;
  logic       hsync_n, vsync_n, csync_n, hblank, vblank, de;
  logic       line_start, frame_start, irq_n;

  int n_checks = 0;
  int n_errors = 0;

  video_timing_gen #(
    .PIX_DIV(2), .H_TOTAL(10), .H_ACTIVE(6), .H_SYNC_START(7), .H_SYNC_WIDTH(2),
    .V_TOTAL(6), .V_ACTIVE(4), .V_SYNC_START(4), .V_SYNC_WIDTH(1), .IRQ_LINE(4)
  ) dut (
    .clk(clk), .rst(rst), .irq_en(irq_en), .irq_ack(irq_ack),
    .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n),
    .hblank(hblank), .vblank(vblank), .de(de),
    .line_start(line_start), .frame_start(frame_start), .irq_n(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic ack;
    logic pce;
    int   h;
    int   v;
    logic hb;
    logic hs_n;
    logic ls;
    logic de;
    logic irq_n;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input int tag);
    chk("rst_pix_ce", tag, 32'(pix_ce), 0);
    chk("rst_hcount", tag, 32'(hcount), 0);
    chk("rst_vcount", tag, 32'(vcount), 0);
    chk("rst_irq_n", tag, 32'(irq_n), 1);
    chk("rst_hblank", tag, 32'(hblank), 0);
    chk("rst_vblank", tag, 32'(vblank), 0);
    chk("rst_de", tag, 32'(de), 1);
    chk("rst_line_start", tag, 32'(line_start), 1);
    chk("rst_frame_start", tag, 32'(frame_start), 1);
    chk("rst_hsync_n", tag, 32'(hsync_n), 1);
    chk("rst_vsync_n", tag, 32'(vsync_n), 1);
    chk("rst_csync_n", tag, 32'(csync_n), 1);
  endtask

  // Applies the first 23 post-reset cycles; returns at cycle 23.
  task automatic run_table();
    for (int i = 0; i < 23; i++) begin
      irq_en  = vec[i].en;
      irq_ack = vec[i].ack;
      chk("tbl_pix_ce", i, 32'(pix_ce), 32'(vec[i].pce));
      chk("tbl_hcount", i, 32'(hcount), vec[i].h);
      chk("tbl_vcount", i, 32'(vcount), vec[i].v);
      chk("tbl_hblank", i, 32'(hblank), 32'(vec[i].hb));
      chk("tbl_hsync_n", i, 32'(hsync_n), 32'(vec[i].hs_n));
      chk("tbl_line_start", i, 32'(line_start), 32'(vec[i].ls));
      chk("tbl_de", i, 32'(de), 32'(vec[i].de));
      chk("tbl_irq_n", i, 32'(irq_n), 32'(vec[i].irq_n));
      step();
    end
  endtask

  initial begin
    int   exp_h, exp_v, last_fs;
    logic exp_hs, exp_vs, exp_irq, prev_fs;

    //            en    ack   pce   h  v  hb    hs_n  ls    de    irq_n
    vec[0]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[4]  = '{1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[10] = '{1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[11] = '{1'b0, 1'b0, 1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[12] = '{1'b0, 1'b0, 1'b0, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[13] = '{1'b0, 1'b0, 1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[14] = '{1'b0, 1'b0, 1'b0, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[15] = '{1'b0, 1'b0, 1'b1, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[16] = '{1'b0, 1'b0, 1'b0, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[17] = '{1'b0, 1'b0, 1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[18] = '{1'b0, 1'b0, 1'b0, 9, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[19] = '{1'b0, 1'b0, 1'b1, 9, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[20] = '{1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[21] = '{1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[22] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst     = 1'b1;
    irq_en  = 1'b0;
    irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state(-1);
    rst = 1'b0;
    run_table();

    // Free run past six frames with a scheduled interrupt pattern:
    // set at 320 / ack 325; set+ack together at 439; gated-but-pending at 559; ack 565; set at 680.
    last_fs = 0;
    prev_fs = 1'b0;
    for (int c = 23; c <= 790; c++) begin
      irq_en  = ((c >= 300) && (c < 500)) || (c >= 600);
      irq_ack = (c == 325) || (c == 439) || (c == 565);
      exp_h   = (c / 2) % 10;
      exp_v   = (c / 20) % 6;
      exp_hs  = !((exp_h == 7) || (exp_h == 8));
      exp_vs  = (exp_v != 4);
      exp_irq = !(((c >= 320) && (c <= 325)) || ((c >= 440) && (c <= 565)) || (c >= 680));
      chk("run_pix_ce", c, 32'(pix_ce), 32'(c % 2));
      chk("run_hcount", c, 32'(hcount), exp_h);
      chk("run_vcount", c, 32'(vcount), exp_v);
      chk("run_hblank", c, 32'(hblank), 32'(exp_h >= 6));
      chk("run_vblank", c, 32'(vblank), 32'(exp_v >= 4));
      chk("run_de", c, 32'(de), 32'((exp_h < 6) && (exp_v < 4)));
      chk("run_hsync_n", c, 32'(hsync_n), 32'(exp_hs));
      chk("run_vsync_n", c, 32'(vsync_n), 32'(exp_vs));
      chk("run_csync_n", c, 32'(csync_n), 32'(exp_hs && exp_vs));
      chk("run_line_start", c, 32'(line_start), 32'(exp_h == 0));
      chk("run_frame_start", c, 32'(frame_start), 32'((exp_h == 0) && (exp_v == 0)));
      chk("run_irq_n", c, 32'(irq_n), 32'(exp_irq));
      if (frame_start && !prev_fs) begin
        chk("frame_period", c, 32'(c - last_fs), 120);
        last_fs = c;
      end
      prev_fs = frame_start;
      if (c < 790) step();
    end

    // Reset lands at pixel (5,3) with an interrupt pending.
    rst     = 1'b1;
    irq_en  = 1'b0;
    irq_ack = 1'b0;
    step();
    check_reset_state(791);
    rst = 1'b0;
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade cores. It replaces hard-wired discrete H/V counter chains with one configurable block. It produces the pixel clock enable, horizontal and vertical counters, separate and composite sync, blanking and display-enable, plus a latched CPU interrupt with acknowledge. It sits between the PLL clock and the tile/sprite/bullet render logic and the CPU IRQ input, and is shared by all video modes a core needs.

## Interface

Parameters:
- PIX_DIV, 4: clk cycles per pixel, at least 1. At 1, pix_ce is held high.
- H_TOTAL, 384: pixels per line.
- H_ACTIVE, 256: visible pixels, counted from hcount 0.
- H_SYNC_START, 304: first hcount with hsync asserted.
- H_SYNC_WIDTH, 32: hsync length in pixels.
- V_TOTAL, 264: lines per frame.
- V_ACTIVE, 224: visible lines, counted from vcount 0.
- V_SYNC_START, 240: first vcount with vsync asserted.
- V_SYNC_WIDTH, 8: vsync length in lines.
- IRQ_LINE, 224: vcount at which the interrupt is raised.
- HW, $clog2(H_TOTAL): hcount width.
- VW, $clog2(V_TOTAL): vcount width.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- irq_en, input, 1: when high, the IRQ_LINE event sets the interrupt.
- irq_ack, input, 1: synchronous clear of a pending interrupt (the INTACK decode strobe).
- pix_ce, output, 1: one-clk pixel enable.
- hcount, output, HW: current pixel.
- vcount, output, VW: current line.
- hsync_n, output, 1: horizontal sync, active low.
- vsync_n, output, 1: vertical sync, active low.
- csync_n, output, 1: composite sync, equal to hsync_n AND vsync_n.
- hblank, output, 1: high when hcount ≥ H_ACTIVE.
- vblank, output, 1: high when vcount ≥ V_ACTIVE.
- de, output, 1: equal to !hblank & !vblank.
- line_start, output, 1: high during the pixel where hcount==0.
- frame_start, output, 1: high during the pixel where hcount==0 and vcount==0.
- irq_n, output, 1: interrupt request, active low, level-held until acknowledged.

## Operation

- Divider:
  - div counts 0..PIX_DIV-1 and wraps to 0.
  - pix_ce is registered and is high in the clk cycle where div==PIX_DIV-1.
- Counters advance only on clk edges where pix_ce is high:
  - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 from V_TOTAL-1, which happens only together with the hcount wrap.
- Decodes:
  - hsync_n is low when H_SYNC_START ≤ hcount < H_SYNC_START+H_SYNC_WIDTH. The range is taken modulo H_TOTAL, so sync may wrap past hcount 0.
  - vsync_n uses the same rule on vcount with V_SYNC_START, V_SYNC_WIDTH and V_TOTAL.
  - hblank, vblank, de, line_start and frame_start follow the definitions in the port list.
- Output registers:
  - Every decoded output is a register loaded from the next counter value.
  - Each therefore changes on the same edge as the counters and always matches the current hcount/vcount. There is no lag.
- Interrupt:
  - Set: on the pix_ce edge where the counters move to (hcount=0, vcount=IRQ_LINE) and irq_en=1, irq_n goes low.
  - Clear: irq_n returns high on the clk edge after any cycle with irq_ack=1.
  - Set and ack on the same edge: set wins, and irq_n stays low.
  - irq_en=0 blocks new sets but does not clear a pending interrupt.
- Legality (elaboration-time assertion): H_ACTIVE ≤ H_TOTAL, V_ACTIVE ≤ V_TOTAL, IRQ_LINE < V_TOTAL, and both sync widths ≥ 1 and less than their totals.

## Timing

- Reset, applied on the rst edge, overrides all other activity, including mid-line and mid-frame:
  - div, hcount and vcount go to 0.
  - irq_n goes to 1 and pix_ce to 0.
  - Decoded outputs take their values for (0,0): hblank=0, vblank=0, de=1, line_start=1, frame_start=1. Sync outputs follow their parameters.
- After rst falls:
  - The first pix_ce occurs in clk cycle PIX_DIV-1, counting the first post-reset cycle as 0.
  - The first counter increment happens at that edge.
- Latency:
  - Counters and decodes change on the same edge.
  - irq_n falls on the edge that sets vcount=IRQ_LINE and hcount=0.
  - irq_ack acts with one clk of latency.
- Line period is H_TOTAL×PIX_DIV clk cycles. Frame period is H_TOTAL×V_TOTAL×PIX_DIV clk cycles.
- line_start and frame_start are held for one full pixel, i.e. PIX_DIV clk cycles.

## Test plan

All scenarios use PIX_DIV=2, H_TOTAL=10, H_ACTIVE=6, H_SYNC_START=7, H_SYNC_WIDTH=2, V_TOTAL=6, V_ACTIVE=4, V_SYNC_START=4, V_SYNC_WIDTH=1, IRQ_LINE=4.

- Reset release:
  - Stimulus: release rst.
  - Required: pix_ce is high in clk cycles 1, 3 and 5. hcount reads 1 after cycle 1 and 2 after cycle 3. de=1 and hsync_n=1 throughout.
- Line decode:
  - Stimulus: run one line.
  - Required: hblank is high for hcount 6..9. hsync_n is low only for hcount 7..8. After hcount 9, hcount=0, vcount=1 and line_start=1.
- Frame decode:
  - Stimulus: run one full frame of 120 clk cycles.
  - Required: vblank is high for vcount 4..5. vsync_n and csync_n are low for the whole of line 4. frame_start recurs every 120 clk cycles.
- Interrupt set and ack:
  - Stimulus: irq_en=1, run to line 4, then pulse irq_ack for one cycle.
  - Required: irq_n falls on the edge to (0,4) and rises one clk after the ack.
- Simultaneous set and ack, and gating:
  - Stimulus: assert irq_ack during the setting edge.
  - Required: irq_n stays low.
  - Stimulus: with irq_en=0, run to line 4.
  - Required: irq_n stays high, and an interrupt already pending remains low.
- Mid-frame reset:
  - Stimulus: assert rst at (5,3).
  - Required: the next edge gives hcount=0, vcount=0 and irq_n=1. Timing then matches the reset-release scenario exactly.
